// File: rtl/rtc_bus_cycle_pkg.sv
// Shared definitions for the RTC bus-cycle sequencer.
// Contents:
//   - state_t         : FSM state encoding. The write-verify read re-runs the
//                       normal phase states with a pass flag set, so the verify
//                       pass has no separate V_* states (IDLE plus two full
//                       passes would not fit in 4 bits).
//   - DEF_T_*         : default per-phase timing in clock cycles.
//   - RTC_REG_*       : register addresses of the external RTC chip.
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_A_SU   = 4'd1,
    ST_A_STB  = 4'd2,
    ST_A_HOLD = 4'd3,
    ST_A_REC  = 4'd4,
    ST_D_SU   = 4'd5,
    ST_D_STB  = 4'd6,
    ST_D_HOLD = 4'd7,
    ST_D_REC  = 4'd8
  } state_t;

  localparam int unsigned DEF_T_SU   = 2;
  localparam int unsigned DEF_T_STB  = 4;
  localparam int unsigned DEF_T_HOLD = 2;
  localparam int unsigned DEF_T_REC  = 3;

  localparam logic [7:0] RTC_REG_SEC      = 8'h20;
  localparam logic [7:0] RTC_REG_MIN      = 8'h21;
  localparam logic [7:0] RTC_REG_HOUR     = 8'h22;
  localparam logic [7:0] RTC_REG_DAY      = 8'h23;
  localparam logic [7:0] RTC_REG_MONTH    = 8'h24;
  localparam logic [7:0] RTC_REG_YEAR     = 8'h25;
  localparam logic [7:0] RTC_REG_TMR_SEC  = 8'h26;
  localparam logic [7:0] RTC_REG_TMR_MIN  = 8'h27;
  localparam logic [7:0] RTC_REG_TMR_HOUR = 8'h28;
  localparam logic [7:0] RTC_REG_CMD      = 8'h2F;

endpackage

// File: rtl/rtc_bus_cycle_if.sv
// Request and chip-bus signals of the RTC bus-cycle sequencer.
// Request side: start/rw/addr/wdata in; busy/done/rdata/rdata_valid/verify_err out.
// Chip side   : AD/CS/RD/WR (active low), ad_out/ad_oe drive, ad_in sample.
// Debug       : dbg_state mirrors the sequencer FSM state.
// Handshake: a request is accepted on a clock edge where start=1 and busy=0;
// rw/addr/wdata are sampled on that same edge; done pulses for one cycle when
// the transaction ends and busy drops in that same cycle.
interface rtc_bus_cycle_if;
  logic                start;
  logic                rw;
  logic [7:0]          addr;
  logic [7:0]          wdata;
  logic                busy;
  logic                done;
  logic [7:0]          rdata;
  logic                rdata_valid;
  logic                verify_err;
  logic                AD;
  logic                CS;
  logic                RD;
  logic                WR;
  logic [7:0]          ad_out;
  logic                ad_oe;
  logic [7:0]          ad_in;
  rtc_bus_pkg::state_t dbg_state;

  modport slave (
    input  start, rw, addr, wdata, ad_in,
    output busy, done, rdata, rdata_valid, verify_err,
    output AD, CS, RD, WR, ad_out, ad_oe, dbg_state
  );

  modport master (
    output start, rw, addr, wdata, ad_in,
    input  busy, done, rdata, rdata_valid, verify_err,
    input  AD, CS, RD, WR, ad_out, ad_oe, dbg_state
  );
endinterface

// File: rtl/rtc_bus_cycle_phase_timer.sv
// rtc_phase_timer: loadable 8-bit down-counter timing one FSM phase.
// Ports: clk_i, rst_i (async, active high), load_i/value_i load the count,
// expire_o is high while the count is zero (the last cycle of a phase).
// A phase of N cycles is timed by loading N-1 on entry.
module rtc_phase_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] value_i,
  output logic       expire_o
);
  logic [7:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q != 8'd0) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign expire_o = (cnt_q == 8'd0);
endmodule

// File: rtl/rtc_bus_cycle.sv
// rtc_bus_cycle: bus-cycle sequencer for the external RTC chip.
// Runs an address phase (always a WR strobe) followed by a read or write
// data phase, each phase split into setup / strobe / hold / recovery with
// programmable lengths T_SU, T_STB, T_HOLD, T_REC (each 1..255).
// Ports: clock, reset (async, active high), bus (rtc_bus_cycle_if.slave).
// Optional macro RTC_WRITE_VERIFY_EN: each write is followed by a read-back
// of the same address; verify_err flags a mismatch. Without it verify_err=0.
// Every output is a flop, computed from the next state and next request.
module rtc_bus_cycle
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_SU   = DEF_T_SU,
  parameter int unsigned T_STB  = DEF_T_STB,
  parameter int unsigned T_HOLD = DEF_T_HOLD,
  parameter int unsigned T_REC  = DEF_T_REC
) (
  input logic           clock,
  input logic           reset,
  rtc_bus_cycle_if.slave bus
);

  if (T_SU == 0 || T_SU > 255) begin : g_bad_t_su
    $error("rtc_bus_cycle: T_SU must be in 1..255");
  end
  if (T_STB == 0 || T_STB > 255) begin : g_bad_t_stb
    $error("rtc_bus_cycle: T_STB must be in 1..255");
  end
  if (T_HOLD == 0 || T_HOLD > 255) begin : g_bad_t_hold
    $error("rtc_bus_cycle: T_HOLD must be in 1..255");
  end
  if (T_REC == 0 || T_REC > 255) begin : g_bad_t_rec
    $error("rtc_bus_cycle: T_REC must be in 1..255");
  end

  localparam logic [7:0] LD_SU   = 8'(T_SU - 1);
  localparam logic [7:0] LD_STB  = 8'(T_STB - 1);
  localparam logic [7:0] LD_HOLD = 8'(T_HOLD - 1);
  localparam logic [7:0] LD_REC  = 8'(T_REC - 1);

  state_t     state_q, state_d;
  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic       rvalid_q, rvalid_d, done_q, done_d, busy_q, busy_d;
  logic       ad_n_q, ad_n_d, cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic       oe_q, oe_d;
  logic [7:0] out_q, out_d;
  logic       tmr_load, tmr_expire;
  logic [7:0] tmr_val;
`ifdef RTC_WRITE_VERIFY_EN
  logic       vpass_q, vpass_d, verr_q, verr_d;
`endif

  rtc_phase_timer u_timer (
    .clk_i   (clock),
    .rst_i   (reset),
    .load_i  (tmr_load),
    .value_i (tmr_val),
    .expire_o(tmr_expire)
  );

  // Next-state, request latch and status logic.
  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = 8'd0;
`ifdef RTC_WRITE_VERIFY_EN
    vpass_d  = vpass_q;
    verr_d   = verr_q;
`endif
    case (state_q)
      ST_IDLE: if (bus.start) begin
        state_d  = ST_A_SU;
        rw_d     = bus.rw;
        addr_d   = bus.addr;
        wdata_d  = bus.wdata;
        tmr_load = 1'b1;
        tmr_val  = LD_SU;
`ifdef RTC_WRITE_VERIFY_EN
        vpass_d  = 1'b0;
        verr_d   = 1'b0;
`endif
      end
      ST_A_SU:   if (tmr_expire) begin state_d = ST_A_STB;  tmr_load = 1'b1; tmr_val = LD_STB;  end
      ST_A_STB:  if (tmr_expire) begin state_d = ST_A_HOLD; tmr_load = 1'b1; tmr_val = LD_HOLD; end
      ST_A_HOLD: if (tmr_expire) begin state_d = ST_A_REC;  tmr_load = 1'b1; tmr_val = LD_REC;  end
      ST_A_REC:  if (tmr_expire) begin state_d = ST_D_SU;   tmr_load = 1'b1; tmr_val = LD_SU;   end
      ST_D_SU:   if (tmr_expire) begin state_d = ST_D_STB;  tmr_load = 1'b1; tmr_val = LD_STB;  end
      ST_D_STB: if (tmr_expire) begin
        state_d  = ST_D_HOLD;
        tmr_load = 1'b1;
        tmr_val  = LD_HOLD;
        // Capture at the end of the strobe, when the chip's data has settled.
        if (rw_q) begin
          rdata_d  = bus.ad_in;
          rvalid_d = 1'b1;
`ifdef RTC_WRITE_VERIFY_EN
          if (vpass_q) verr_d = (bus.ad_in != wdata_q);
`endif
        end
      end
      ST_D_HOLD: if (tmr_expire) begin state_d = ST_D_REC; tmr_load = 1'b1; tmr_val = LD_REC; end
      ST_D_REC: if (tmr_expire) begin
`ifdef RTC_WRITE_VERIFY_EN
        // A finished write turns into a read-back pass of the same address.
        if (!rw_q && !vpass_q) begin
          state_d  = ST_A_SU;
          rw_d     = 1'b1;
          vpass_d  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = LD_SU;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
`else
        state_d = ST_IDLE;
        done_d  = 1'b1;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Bus strobes for the state being entered, so they appear registered.
  always_comb begin
    ad_n_d = 1'b1;
    cs_n_d = 1'b1;
    rd_n_d = 1'b1;
    wr_n_d = 1'b1;
    oe_d   = 1'b0;
    out_d  = 8'd0;
    case (state_d)
      ST_A_SU, ST_A_STB, ST_A_HOLD: begin
        cs_n_d = 1'b0;
        ad_n_d = 1'b0;
        oe_d   = 1'b1;
        out_d  = addr_d;
        wr_n_d = (state_d != ST_A_STB);
      end
      ST_D_SU, ST_D_STB, ST_D_HOLD: begin
        cs_n_d = 1'b0;
        if (rw_d) begin
          rd_n_d = (state_d != ST_D_STB);
        end else begin
          oe_d   = 1'b1;
          out_d  = wdata_d;
          wr_n_d = (state_d != ST_D_STB);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rw_q     <= 1'b0;
      addr_q   <= 8'd0;
      wdata_q  <= 8'd0;
      rdata_q  <= 8'd0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ad_n_q   <= 1'b1;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      oe_q     <= 1'b0;
      out_q    <= 8'd0;
`ifdef RTC_WRITE_VERIFY_EN
      vpass_q  <= 1'b0;
      verr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ad_n_q   <= ad_n_d;
      cs_n_q   <= cs_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      oe_q     <= oe_d;
      out_q    <= out_d;
`ifdef RTC_WRITE_VERIFY_EN
      vpass_q  <= vpass_d;
      verr_q   <= verr_d;
`endif
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rvalid_q;
  assign bus.AD          = ad_n_q;
  assign bus.CS          = cs_n_q;
  assign bus.RD          = rd_n_q;
  assign bus.WR          = wr_n_q;
  assign bus.ad_out      = out_q;
  assign bus.ad_oe       = oe_q;
  assign bus.dbg_state   = state_q;
`ifdef RTC_WRITE_VERIFY_EN
  assign bus.verify_err  = verr_q;
`else
  assign bus.verify_err  = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Testbench for rtc_bus_cycle with default timing (transaction = 22 cycles).
module tb_rtc_bus_cycle;

`ifdef RTC_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int LEN   = 2 * (2 + 4 + 2 + 3);
  localparam int T_STB = 4;
  localparam int T_REC = 3;

  typedef struct {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rback;
    int         exp_len;
    int         exp_wr;
    int         exp_rd;
    int         exp_a;
    int         exp_d;
    int         exp_rv;
    logic [7:0] exp_rdata;
    int         exp_verr;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [7:0] exp_q[$];
  logic [7:0] last_rdata;
  vec_t vecs[$];

  rtc_bus_cycle_if bus_if ();

  rtc_bus_cycle dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus_if)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic vec_t mk(input logic rw, input logic [7:0] addr,
                              input logic [7:0] wdata, input logic [7:0] rback);
    vec_t v;
    v.rw        = rw;
    v.addr      = addr;
    v.wdata     = wdata;
    v.rback     = rback;
    v.exp_len   = (!rw && VERIFY) ? 2 * LEN : LEN;
    v.exp_wr    = rw ? 4 : (VERIFY ? 12 : 8);
    v.exp_rd    = (rw || VERIFY) ? 4 : 0;
    v.exp_a     = (!rw && VERIFY) ? 8 : 4;
    v.exp_d     = rw ? 0 : 4;
    v.exp_rv    = (rw || VERIFY) ? 1 : 0;
    v.exp_rdata = rback;
    v.exp_verr  = (!rw && VERIFY && (rback != wdata)) ? 1 : 0;
    return v;
  endfunction

  // Driver + monitor for one transaction; starts and ends at a negedge.
  task automatic run_txn(input vec_t v, input string tag);
    int done_k, wr_lo, rd_lo, rd_run, a_ok, d_ok, rv_cnt, bad_busy, bad_ovl, bad_rdoe;
    done_k = -1; wr_lo = 0; rd_lo = 0; rd_run = 0; a_ok = 0; d_ok = 0;
    rv_cnt = 0; bad_busy = 0; bad_ovl = 0; bad_rdoe = 0;
    bus_if.start = 1'b1;
    bus_if.rw    = v.rw;
    bus_if.addr  = v.addr;
    bus_if.wdata = v.wdata;
    if (v.rw || VERIFY) exp_q.push_back(v.exp_rdata);
    @(posedge clk);
    #1;
    // Scramble request fields: the DUT must hold the latched copy.
    bus_if.start = 1'b0;
    bus_if.rw    = 1'($urandom_range(0, 1));
    bus_if.addr  = 8'($urandom_range(0, 255));
    bus_if.wdata = 8'($urandom_range(0, 255));
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!bus_if.WR) wr_lo++;
      if (!bus_if.RD) begin rd_lo++; rd_run++; end else rd_run = 0;
      if (!bus_if.WR && !bus_if.AD && !bus_if.CS && bus_if.ad_oe && bus_if.ad_out == v.addr) a_ok++;
      if (!bus_if.WR && bus_if.AD && !bus_if.CS && bus_if.ad_oe && bus_if.ad_out == v.wdata) d_ok++;
      if ((!bus_if.RD && !bus_if.WR) || (!bus_if.RD && bus_if.ad_oe)) bad_ovl++;
      if (v.rw && bus_if.AD && !bus_if.CS && bus_if.ad_oe) bad_rdoe++;
      if (bus_if.busy != (k < v.exp_len)) bad_busy++;
      // Chip model: valid data only on the last strobe cycle.
      bus_if.ad_in = (!bus_if.RD && rd_run == T_STB) ? v.rback : ~v.rback;
      if (bus_if.rdata_valid) begin
        rv_cnt++;
        if (exp_q.size() > 0) begin
          last_rdata = exp_q.pop_front();
          check({tag, "_rdata"}, bus_if.rdata, last_rdata);
        end
      end
      if (bus_if.done) begin
        done_k = k;
        break;
      end
    end
    check({tag, "_done_cycle"}, done_k, v.exp_len);
    check({tag, "_wr_low"}, wr_lo, v.exp_wr);
    check({tag, "_rd_low"}, rd_lo, v.exp_rd);
    check({tag, "_addr_cycles"}, a_ok, v.exp_a);
    check({tag, "_data_cycles"}, d_ok, v.exp_d);
    check({tag, "_rvalid_pulses"}, rv_cnt, v.exp_rv);
    check({tag, "_busy_bad"}, bad_busy, 0);
    check({tag, "_overlap_bad"}, bad_ovl, 0);
    check({tag, "_read_oe_bad"}, bad_rdoe, 0);
    check({tag, "_verify_err"}, bus_if.verify_err, v.exp_verr);
    check({tag, "_rdata_hold"}, bus_if.rdata, last_rdata);
    check({tag, "_exp_q_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Start held high: second request taken right after done, CS gap checked.
  task automatic b2b_test();
    int n_done, done1, done2, cs_run, gap, a_ok, d_ok;
    n_done = 0; done1 = -1; done2 = -1; cs_run = 0; gap = -1; a_ok = 0; d_ok = 0;
    bus_if.start = 1'b1;
    bus_if.rw    = 1'b0;
    bus_if.addr  = 8'h21;
    bus_if.wdata = 8'h11;
    if (VERIFY) exp_q.push_back(8'h11);
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (c == 5) begin
        bus_if.rw    = 1'b1;
        bus_if.addr  = 8'h7E;
        bus_if.wdata = 8'hEE;
      end
      if (n_done == 0) begin
        if (!bus_if.WR && !bus_if.AD && bus_if.ad_out == 8'h21) a_ok++;
        if (!bus_if.WR && bus_if.AD && bus_if.ad_out == 8'h11) d_ok++;
      end
      if (bus_if.CS) cs_run++;
      else begin
        if (n_done == 1 && gap < 0) gap = cs_run;
        cs_run = 0;
      end
      bus_if.ad_in = !bus_if.RD ? 8'h11 : 8'hEE;
      if (bus_if.rdata_valid && exp_q.size() > 0) begin
        last_rdata = exp_q.pop_front();
        check("b2b_rdata", bus_if.rdata, last_rdata);
      end
      if (bus_if.done) begin
        n_done++;
        if (n_done == 1) begin
          done1 = c;
          bus_if.rw   = 1'b1;
          bus_if.addr = 8'h22;
          exp_q.push_back(8'h11);
        end else begin
          done2 = c;
          bus_if.start = 1'b0;
          break;
        end
      end
    end
    check("b2b_done1", done1, VERIFY ? 2 * LEN : LEN);
    check("b2b_done_spacing", done2 - done1, LEN + 1);
    check("b2b_cs_gap", gap, T_REC + 1);
    check("b2b_addr_cycles", a_ok, VERIFY ? 8 : 4);
    check("b2b_data_cycles", d_ok, 4);
    check("b2b_exp_q_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Reset during the write data strobe aborts with no done.
  task automatic reset_abort_test();
    int found, bad;
    found = 0; bad = 0;
    bus_if.start = 1'b1;
    bus_if.rw    = 1'b0;
    bus_if.addr  = 8'h24;
    bus_if.wdata = 8'h5A;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!bus_if.WR && bus_if.AD) begin found = 1; break; end
    end
    check("abort_reached_d_stb", found, 1);
    rst = 1'b1;
    #1;
    check("abort_strobes", {bus_if.AD, bus_if.CS, bus_if.RD, bus_if.WR}, 4'hF);
    check("abort_oe", bus_if.ad_oe, 0);
    check("abort_busy", bus_if.busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus_if.done || bus_if.busy || !bus_if.CS) bad++;
    end
    check("abort_no_done", bad, 0);
    last_rdata = 8'h00;
    run_txn(mk(1'b1, 8'h23, 8'h00, 8'hC3), "after_abort");
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    last_rdata = 8'h00;
    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.rw    = 1'b0;
    bus_if.addr  = 8'h00;
    bus_if.wdata = 8'h00;
    bus_if.ad_in = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ctrl", {bus_if.AD, bus_if.CS, bus_if.RD, bus_if.WR, bus_if.ad_oe,
                          bus_if.busy, bus_if.done, bus_if.rdata_valid, bus_if.verify_err}, 9'h1E0);
    end
    check("idle_ad_out", bus_if.ad_out, 0);
    check("idle_rdata", bus_if.rdata, 0);
    check("idle_state", int'(bus_if.dbg_state), 0);

    vecs.push_back(mk(1'b0, 8'h21, 8'h59, 8'h59));
    vecs.push_back(mk(1'b1, 8'h22, 8'h00, 8'h37));
    vecs.push_back(mk(1'b0, 8'h25, 8'hA5, 8'hA5));
    vecs.push_back(mk(1'b1, 8'h20, 8'h00, 8'h00));
    vecs.push_back(mk(1'b1, 8'h2F, 8'h00, 8'hFF));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(1'b0, 8'h12, 8'h12, 8'h13));
    vecs.push_back(mk(1'b0, 8'h12, 8'h12, 8'h12));
    for (int i = 0; i < 4; i++) begin
      logic [7:0] a, w, r;
      a = 8'($urandom_range(0, 255));
      w = 8'($urandom_range(0, 255));
      r = 8'($urandom_range(0, 255));
      if (i[0]) vecs.push_back(mk(1'b1, a, w, r));
      else      vecs.push_back(mk(1'b0, a, w, w));
    end

    foreach (vecs[i]) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    b2b_test();
    repeat (3) @(negedge clk);
    reset_abort_test();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
